// File: rtl/dual_lane_entry_reader_pkg.sv
// Shared entry typedef, sign-magnitude zero constants and zero classifier.
package dual_lane_entry_reader_pkg;
   localparam int DEF_DATA_W = 48;

   typedef logic [DEF_DATA_W-1:0] entry_t;

   localparam entry_t POS_ZERO = '0;
   localparam entry_t NEG_ZERO = {1'b1, {(DEF_DATA_W-1){1'b0}}};

   // Sign-magnitude has two encodings of zero; both count as zero.
   function automatic logic is_zero(input entry_t v);
      return (v == POS_ZERO) || (v == NEG_ZERO);
   endfunction
endpackage

// File: rtl/dual_lane_entry_reader_entry_buf.sv
// entry_buf_2w1r: DEPTH x DATA_W storage, two write ports, registered read; latency 1 cycle.
// Backpressure: none here, rd_en holds rd_data; same-cycle writes forward to the read port.
module entry_buf_2w1r
   import dual_lane_entry_reader_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] data_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] data_b,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_fwd;

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= data_a;
      if (we_b) mem[addr_b] <= data_b;
   end

   // A slot written this cycle may become the head next cycle, so bypass the array.
   always_comb begin
      rd_fwd = mem[rd_addr];
      if (we_b && (addr_b == rd_addr)) rd_fwd = data_b;
      if (we_a && (addr_a == rd_addr)) rd_fwd = data_a;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= rd_fwd;
   end
endmodule

// File: rtl/dual_lane_entry_reader.sv
// Two-lane entry buffer drained in arrival order; write-to-rd_valid latency 1 cycle. ZERO_FILTER_EN drops +0/-0 writes.
// Backpressure: rd_valid/rd_data hold while !rd_ready; writes beyond free space are dropped and flag overflow.
module dual_lane_entry_reader
   import dual_lane_entry_reader_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_en2,
   input  logic [DATA_W-1:0] wr_data2,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              overflow
);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr, rd_ptr, addr_b, rd_addr;
   logic [ADDR_W:0]   free, pushes, count_next;
   logic              q1, q2, acc1, acc2, drop, pop, rd_en;

   // Lane qualification: enable alone, or enable plus non-zero data.
   always_comb begin
`ifdef ZERO_FILTER_EN
      q1 = wr_en  && !is_zero(entry_t'(wr_data));
      q2 = wr_en2 && !is_zero(entry_t'(wr_data2));
`else
      q1 = wr_en;
      q2 = wr_en2;
`endif
   end

   // Space comes from the start-of-cycle count only; a same-cycle pop frees nothing.
   assign free   = DEPTH_C - count;
   assign acc1   = q1 && (free != '0);
   assign acc2   = q2 && (acc1 ? (free >= (ADDR_W+1)'(2)) : (free != '0));
   assign drop   = (q1 && !acc1) || (q2 && !acc2);
   assign pushes = (ADDR_W+1)'(acc1) + (ADDR_W+1)'(acc2);
   assign pop    = rd_valid && rd_ready;

   assign count_next = count + pushes - (ADDR_W+1)'(pop);
   assign addr_b     = acc1 ? (wr_ptr + ADDR_W'(1)) : wr_ptr;
   assign rd_addr    = rd_ptr + ADDR_W'(pop);
   assign rd_en      = pop || ((count == '0) && (pushes != '0));
   assign full       = (count == DEPTH_C);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr + ADDR_W'(acc1) + ADDR_W'(acc2);
         rd_ptr   <= rd_addr;
         count    <= count_next;
         overflow <= overflow | drop;
         rd_valid <= (count_next != '0);
      end
   end

   entry_buf_2w1r #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .we_a    (acc1),
      .addr_a  (wr_ptr),
      .data_a  (wr_data),
      .we_b    (acc2),
      .addr_b  (addr_b),
      .data_b  (wr_data2),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );
endmodule
